joint_phase_stepper: RTL and testbench
======================================

JOINT_PHASE_STEPPER -- requirements
Module: joint_phase_stepper

Interface
REQ-001 SHALL have parameter CMD_WIDTH, default 32, width of the signed frequency (period) command.
REQ-002 SHALL have parameter POS_WIDTH, default 32, width of the signed position feedback.
REQ-003 SHALL have parameter MIN_PERIOD, default 2, the lower clamp on the step period count.
REQ-004 SHALL have parameter HOLD_ON_DISABLE, default 0; 1 keeps the last coil pattern while disabled.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port jointEnable  input  1  drive enable.
REQ-008 SHALL have port jointFreqCmd  input  CMD_WIDTH signed  step period in clk cycles; sign gives direction; 0 means stop.
REQ-009 SHALL have port stepMode  input  2  0 wave, 1 full two-phase, 2 or 3 half-step.
REQ-010 SHALL have ports a1, a2, b1, b2  output  1 each  registered coil drives.
REQ-011 SHALL have port jointFeedback  output  POS_WIDTH signed  accumulated step position.
REQ-012 SHALL have port stepPulse  output  1  one-cycle strobe on each taken step.

Function
REQ-013 SHALL register cmdAbs = |jointFreqCmd| one cycle after the input; -2^(CMD_WIDTH-1) saturates to 2^(CMD_WIDTH-1)-1.
REQ-014 SHALL use effective period P = max(cmdAbs, MIN_PERIOD).
REQ-015 SHALL increment the period counter every cycle while enabled and cmd != 0; on counter >= P, assert a step event and clear the counter, so steps occur every P+1 cycles.
REQ-016 SHALL hold the period counter at 0 and issue no step while jointEnable=0 or jointFreqCmd=0.
REQ-017 SHALL take direction forward when jointFreqCmd > 0, reverse when < 0, sampled at the step event.
REQ-018 SHALL keep a 3-bit phase index; half-step table: 0 A1; 1 A1+B1; 2 B1; 3 B1+A2; 4 A2; 5 A2+B2; 6 B2; 7 B2+A1.
REQ-019 SHALL advance the index by ±1 in half mode, or when the index parity mismatches the mode (wave needs even, full needs odd); otherwise by ±2; wrap modulo 8.
REQ-020 SHALL update coil outputs and stepPulse one cycle after the step event (one-cycle registered latency).
REQ-021 SHALL add +1 (forward) or -1 (reverse) to jointFeedback per step, wrapping two's-complement at POS_WIDTH.
REQ-022 SHALL drive all coils 0 while jointEnable=0 when HOLD_ON_DISABLE=0, or the table pattern of the current index when 1.
REQ-023 SHALL, on re-enable, resume from the retained index and position without a spurious step.
REQ-024 SHALL apply a mode change at the next step event only; coils do not change on a mode change alone.
REQ-025 SHALL apply a new command magnitude to the running count immediately; if counter >= new P, step on the next cycle.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force counter 0, cmdAbs 0, index 0, jointFeedback 0, stepPulse 0, a1=a2=b1=b2=0.
REQ-027 SHALL abort any in-progress period on reset mid-operation; the first step after release occurs no earlier than P+1 cycles after an enabled non-zero command is seen.

Structure
REQ-028 SHALL place the 8-entry phase table constant and the step-mode encodings in shared package joint_stepper_pkg.
REQ-029 SHALL implement the period counter, clamp and step-event generation in sub-module joint_step_rate_gen.

Verification
REQ-030 SHALL cover: mode 2, cmd=+10, enable -> stepPulse every 11 cycles, index 0,1,2..7,0, feedback +1 per step.
REQ-031 SHALL cover: mode 0 from index 1, cmd=-5 -> first step to index 0, then 6,4,2, coils single-phase only, feedback decrements.
REQ-032 SHALL cover: cmd=+1 with MIN_PERIOD=2 -> steps every 3 cycles; cmd=-2^31 -> no overflow, forward never taken.
REQ-033 SHALL cover: enable dropped mid-run, HOLD_ON_DISABLE=0 then 1 -> coils 0 vs last pattern held; re-enable resumes index, no extra step.
REQ-034 SHALL cover: rst_n pulsed low mid-period at index 5, feedback 37 -> all outputs 0 immediately, feedback 0, index 0 after release.

Source files
------------

// File: rtl/joint_stepper_pkg.sv
// joint_stepper_pkg: step-mode encodings, coil phase table and phase-advance helper
// shared by the joint stepper blocks.
package joint_stepper_pkg;

    typedef enum logic [1:0] {
        MODE_WAVE     = 2'd0,
        MODE_FULL     = 2'd1,
        MODE_HALF     = 2'd2,
        MODE_HALF_ALT = 2'd3
    } step_mode_e;

    typedef struct packed {
        logic a1;
        logic a2;
        logic b1;
        logic b2;
    } coil_t;

    localparam coil_t PHASE_TABLE [8] = '{
        4'b1000,
        4'b1010,
        4'b0010,
        4'b0110,
        4'b0100,
        4'b0101,
        4'b0001,
        4'b1001
    };

    // Wave settles on even indices and full-step on odd ones, so a parity mismatch
    // takes a single half-step to realign before regular double steps resume.
    function automatic logic [2:0] next_phase(input logic [2:0] idx,
                                              input logic [1:0] mode,
                                              input logic       fwd);
        logic single;
        single = mode[1] || (idx[0] != (mode == MODE_FULL));
        return fwd ? idx + (single ? 3'd1 : 3'd2) : idx - (single ? 3'd1 : 3'd2);
    endfunction

endpackage

// File: rtl/joint_step_rate_gen.sv
// joint_step_rate_gen: converts a signed period command into a step event every
// max(|cmd|, MIN_PERIOD)+1 enabled cycles.
module joint_step_rate_gen
    import joint_stepper_pkg::*;
#(
    parameter int CMD_WIDTH  = 32,
    parameter int MIN_PERIOD = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic signed [CMD_WIDTH-1:0] cmd,
    output logic                        step_evt
);

    localparam logic [CMD_WIDTH-1:0] MIN_P   = CMD_WIDTH'(MIN_PERIOD);
    localparam logic [CMD_WIDTH-1:0] MAX_ABS = {1'b0, {(CMD_WIDTH-1){1'b1}}};
    localparam logic [CMD_WIDTH-1:0] MOST_NEG = {1'b1, {(CMD_WIDTH-1){1'b0}}};
    localparam logic [CMD_WIDTH-1:0] ONE     = CMD_WIDTH'(1);

    logic [CMD_WIDTH-1:0] cmd_abs_d, cmd_abs_q;
    logic [CMD_WIDTH-1:0] cnt_d, cnt_q;
    logic [CMD_WIDTH-1:0] period;
    logic                 run;

    // The most negative command has no positive twin, so it saturates instead of wrapping.
    always_comb begin
        cmd_abs_d = cmd[CMD_WIDTH-1]
                  ? ((cmd == MOST_NEG) ? MAX_ABS : $unsigned(-cmd))
                  : $unsigned(cmd);
        period    = (cmd_abs_q > MIN_P) ? cmd_abs_q : MIN_P;
        run       = enable && (cmd != '0);
        step_evt  = run && (cnt_q >= period);
        cnt_d     = (run && !step_evt) ? cnt_q + ONE : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_abs_q <= '0;
            cnt_q     <= '0;
        end else begin
            cmd_abs_q <= cmd_abs_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/joint_phase_stepper.sv
// joint_phase_stepper: two-coil stepper phase sequencer with wave, full and half-step
// modes, registered coil drives, step strobe and signed position feedback.
module joint_phase_stepper
    import joint_stepper_pkg::*;
#(
    parameter int CMD_WIDTH       = 32,
    parameter int POS_WIDTH       = 32,
    parameter int MIN_PERIOD      = 2,
    parameter int HOLD_ON_DISABLE = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        jointEnable,
    input  logic signed [CMD_WIDTH-1:0] jointFreqCmd,
    input  logic [1:0]                  stepMode,
    output logic                        a1,
    output logic                        a2,
    output logic                        b1,
    output logic                        b2,
    output logic signed [POS_WIDTH-1:0] jointFeedback,
    output logic                        stepPulse
);

    localparam logic signed [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);

    logic                        step_evt;
    logic                        fwd;
    logic [2:0]                  idx_d, idx_q;
    logic signed [POS_WIDTH-1:0] pos_d, pos_q;
    logic                        pulse_d, pulse_q;
    coil_t                       coil_d, coil_q;

    joint_step_rate_gen #(
        .CMD_WIDTH  (CMD_WIDTH),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_rate_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (jointEnable),
        .cmd      (jointFreqCmd),
        .step_evt (step_evt)
    );

    // Coils follow the index only, so a mode change alone never moves them.
    always_comb begin
        fwd     = !jointFreqCmd[CMD_WIDTH-1];
        idx_d   = step_evt ? next_phase(idx_q, stepMode, fwd) : idx_q;
        pos_d   = step_evt ? (fwd ? pos_q + POS_ONE : pos_q - POS_ONE) : pos_q;
        pulse_d = step_evt;
        coil_d  = (jointEnable || (HOLD_ON_DISABLE != 0)) ? PHASE_TABLE[idx_d] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            pos_q   <= '0;
            pulse_q <= 1'b0;
            coil_q  <= '0;
        end else begin
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            pulse_q <= pulse_d;
            coil_q  <= coil_d;
        end
    end

    assign {a1, a2, b1, b2} = coil_q;
    assign jointFeedback    = pos_q;
    assign stepPulse        = pulse_q;

endmodule

// File: tb/tb_joint_phase_stepper.sv
// tb_joint_phase_stepper: directed and randomized checks of two stepper instances
// (coils released vs held on disable) against a cycle-level behavioural model.
module tb_joint_phase_stepper;

    localparam int MINP = 2;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              en    = 1'b0;
    logic signed [31:0] cmd  = '0;
    logic [1:0]        mode  = '0;

    logic a1_0, a2_0, b1_0, b2_0, sp_0;
    logic a1_1, a2_1, b1_1, b2_1, sp_1;
    logic signed [31:0] fb_0, fb_1;

    int tests = 0;
    int fails = 0;

    longint m_abs, m_el, m_pos;
    int     m_idx;
    bit     m_pulse, m_en_prev;
    int     cyc = 0, last_pulse = -1, gap_exp = 0;
    int     steps, fb_snap;

    always #5 clk = ~clk;

    joint_phase_stepper #(.HOLD_ON_DISABLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .jointEnable(en), .jointFreqCmd(cmd), .stepMode(mode),
        .a1(a1_0), .a2(a2_0), .b1(b1_0), .b2(b2_0), .jointFeedback(fb_0), .stepPulse(sp_0)
    );

    joint_phase_stepper #(.HOLD_ON_DISABLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .jointEnable(en), .jointFreqCmd(cmd), .stepMode(mode),
        .a1(a1_1), .a2(a2_1), .b1(b1_1), .b2(b2_1), .jointFeedback(fb_1), .stepPulse(sp_1)
    );

    // Coil set for a phase: each coil is energised across three consecutive indices.
    function automatic logic [3:0] pat(input int i);
        return {(i == 7 || i == 0 || i == 1), (i >= 3 && i <= 5), (i >= 1 && i <= 3), (i >= 5)};
    endfunction

    // Move one half-step, then once more if the landing index has the wrong parity.
    function automatic int next_idx(input int i, input int md, input int dir);
        int j;
        j = ((i + dir) % 8 + 8) % 8;
        if (md < 2 && (j % 2) != (md == 1 ? 1 : 0)) j = ((j + dir) % 8 + 8) % 8;
        return j;
    endfunction

    function automatic longint abs_sat(input longint v);
        longint a;
        a = (v < 0) ? -v : v;
        return (a > 64'sd2147483647) ? 64'sd2147483647 : a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] coils0();
        return {a1_0, a2_0, b1_0, b2_0};
    endfunction

    function automatic logic [3:0] coils1();
        return {a1_1, a2_1, b1_1, b2_1};
    endfunction

    task automatic check_outputs();
        chk("pulse", 32'(sp_0), 32'(m_pulse));
        chk("pulse_hold", 32'(sp_1), 32'(m_pulse));
        chk("feedback", fb_0, m_pos[31:0]);
        chk("feedback_hold", fb_1, m_pos[31:0]);
        chk("coils", 32'(coils0()), m_en_prev ? 32'(pat(m_idx)) : 32'd0);
        chk("coils_hold", 32'(coils1()), 32'(pat(m_idx)));
        if (sp_0) begin
            if (gap_exp > 0 && last_pulse >= 0) chk("step_gap", cyc - last_pulse, gap_exp);
            last_pulse = cyc;
        end
    endtask

    task automatic tick();
        longint p;
        bit     run, stp;
        int     dir;
        p   = (m_abs > MINP) ? m_abs : MINP;
        run = en && (cmd != 0);
        stp = run && (m_el >= p);
        m_el = (run && !stp) ? m_el + 1 : 0;
        dir = (cmd > 0) ? 1 : -1;
        if (stp) begin
            m_idx = next_idx(m_idx, mode, dir);
            m_pos = m_pos + dir;
        end
        m_pulse   = stp;
        m_en_prev = en;
        m_abs     = abs_sat(cmd);
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_coils", 32'(coils0()), 32'd0);
        chk("rst_coils_hold", 32'(coils1()), 32'd0);
        chk("rst_feedback", fb_0, 32'd0);
        chk("rst_pulse", 32'(sp_0), 32'd0);
        m_abs = 0; m_el = 0; m_idx = 0; m_pos = 0; m_pulse = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        tick();

        // half-step forward at period 10
        mode = 2'd2; cmd = 10; tick();
        en = 1'b1; gap_exp = 11; last_pulse = -1;
        repeat (88) tick();
        chk("half_fb", fb_0, 32'd8);
        chk("half_wrap_coils", 32'(coils0()), 32'b1000);

        // reach index 1, then wave reverse
        for (int i = 0; i < 20 && m_idx != 1; i++) tick();
        chk("at_idx1", 32'(coils0()), 32'b1010);
        mode = 2'd0; cmd = -5; gap_exp = 0; last_pulse = -1; steps = 0;
        for (int i = 0; i < 60 && steps < 4; i++) begin
            tick();
            if (sp_0) begin
                steps++;
                chk("wave_single", $countones(coils0()), 32'd1);
                gap_exp = 6;
            end
        end
        chk("wave_fb", fb_0, 32'd5);
        chk("wave_coils", 32'(coils0()), 32'b0010);

        // period clamp and saturated negative command
        mode = 2'd2; cmd = 1; gap_exp = 0; last_pulse = -1;
        for (int i = 0; i < 10 && !sp_0; i++) tick();
        gap_exp = 3;
        repeat (15) tick();
        cmd = 32'sh8000_0000; gap_exp = 0;
        tick();
        fb_snap = fb_0;
        repeat (40) tick();
        chk("minneg_no_fwd", 32'($signed(fb_0) <= fb_snap), 32'd1);

        // shrinking the period takes effect on the running count
        cmd = 0; tick();
        cmd = 20; repeat (15) tick();
        cmd = 4; tick(); tick();
        chk("shrink_step", 32'(sp_0), 32'd1);

        // disable mid-run, then resume without an extra step
        mode = 2'd1; cmd = 7; repeat (20) tick();
        en = 1'b0; fb_snap = fb_0;
        repeat (10) tick();
        chk("dis_coils", 32'(coils0()), 32'd0);
        chk("dis_hold", 32'(coils1()), 32'(pat(m_idx)));
        en = 1'b1;
        repeat (7) tick();
        chk("resume_no_step", fb_0, fb_snap);
        tick();
        chk("resume_step", 32'(sp_0), 32'd1);

        // randomized commands, modes and enables
        for (int i = 0; i < 40; i++) begin
            int mag;
            mag  = int'($urandom_range(0, 12));
            cmd  = ($urandom_range(0, 1) != 0) ? -mag : mag;
            mode = 2'($urandom_range(0, 3));
            en   = ($urandom_range(0, 9) != 0);
            repeat ($urandom_range(1, 20)) tick();
        end

        // reset in the middle of a period at index 5, feedback 37
        do_reset();
        en = 1'b0; mode = 2'd2; cmd = 1; tick();
        en = 1'b1;
        for (int i = 0; i < 200 && m_pos != 37; i++) tick();
        tick();
        chk("pre_rst_fb", fb_0, 32'd37);
        chk("pre_rst_coils", 32'(coils0()), 32'b0101);
        do_reset();
        tick();
        chk("post_rst_coils", 32'(coils0()), 32'b1000);
        chk("post_rst_fb", fb_0, 32'd0);
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
